e203_exu_flush_arb: RTL and testbench



---
 rtl/e203_exu_flush_arb.sv | 169 ++++++++++++++++
 tb/tb_e203_exu_flush_arb.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_flush_arb.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// e203_exu_flush_arb : locked priority flush arbiter with BHT writeback queue
// Rev 1.0
// -----------------------------------------------------------------------------
module e203_exu_flush_arb #(
  parameter int CH_NUM   = 3,
  parameter int PC_SIZE  = 32,
  parameter int BQ_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH_NUM-1:0]         cmt_flush_req,
  input  logic [CH_NUM*PC_SIZE-1:0] cmt_flush_add_op1,
  input  logic [CH_NUM*PC_SIZE-1:0] cmt_flush_add_op2,
  output logic [CH_NUM-1:0]         cmt_flush_ack,
  output logic                      pipe_flush_req,
  output logic [PC_SIZE-1:0]        pipe_flush_add_op1,
  output logic [PC_SIZE-1:0]        pipe_flush_add_op2,
  input  logic                      pipe_flush_ack,
  output logic                      flush_pulse,
  output logic [CNT_W-1:0]          flush_cnt,
  input  logic                      bjp_wb_valid,
  input  logic [PC_SIZE-1:0]        bjp_wb_pc,
  input  logic                      bjp_wb_prdt,
  input  logic                      bjp_wb_rslv,
  output logic                      bht_wb_valid,
  input  logic                      bht_wb_ready,
  output logic [PC_SIZE-1:0]        bht_wb_pc,
  output logic                      bht_wb_taken,
  output logic                      bht_wb_mis,
  output logic                      bq_drop
);

  localparam int GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int AW = $clog2(BQ_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic [GW-1:0]      gnt_idx;
  logic [GW-1:0]      gnt_idx_nxt;
  logic [GW-1:0]      prio_idx;
  logic [GW-1:0]      sel_idx;
  logic               any_req;
  logic               handshake;
  logic [PC_SIZE-1:0] op1_arr [CH_NUM];
  logic [PC_SIZE-1:0] op2_arr [CH_NUM];

  generate
    for (genvar i = 0; i < CH_NUM; i++) begin : g_unpack
      assign op1_arr[i] = cmt_flush_add_op1[i*PC_SIZE +: PC_SIZE];
      assign op2_arr[i] = cmt_flush_add_op2[i*PC_SIZE +: PC_SIZE];
    end
  endgenerate

  assign any_req = |cmt_flush_req;

  // Lowest requesting index wins; channel 0 is the most urgent.
  always_comb begin
    prio_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (cmt_flush_req[i]) begin
        prio_idx = GW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      gnt_idx <= '0;
    end else begin
      state   <= state_nxt;
      gnt_idx <= gnt_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_idx_nxt = gnt_idx;
    case (state)
      S_IDLE: begin
        if (any_req && !pipe_flush_ack) begin
          state_nxt   = S_HOLD;
          gnt_idx_nxt = prio_idx;
        end
      end
      S_HOLD: begin
        // Leave on completion, or when the locked requester withdraws.
        if (!cmt_flush_req[gnt_idx] || pipe_flush_ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sel_idx            = (state == S_HOLD) ? gnt_idx : prio_idx;
    pipe_flush_req     = (state == S_HOLD) ? cmt_flush_req[gnt_idx] : any_req;
    pipe_flush_add_op1 = op1_arr[sel_idx];
    pipe_flush_add_op2 = op2_arr[sel_idx];
    handshake          = pipe_flush_req & pipe_flush_ack;
    flush_pulse        = handshake;
    cmt_flush_ack      = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      cmt_flush_ack[i] = handshake && (sel_idx == GW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (flush_pulse) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Branch writeback queue: pointers carry an extra wrap bit to tell full from empty.
  logic [AW:0]         wptr;
  logic [AW:0]         rptr;
  logic [PC_SIZE-1:0]  pc_mem [BQ_DEPTH];
  logic [BQ_DEPTH-1:0] taken_mem;
  logic [BQ_DEPTH-1:0] mis_mem;
  logic                bq_empty;
  logic                bq_full;
  logic                bq_push;
  logic                bq_pop;

  assign bq_empty = (wptr == rptr);
  assign bq_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign bq_pop   = !bq_empty && bht_wb_ready;
  assign bq_push  = bjp_wb_valid && (!bq_full || bq_pop);
  assign bq_drop  = bjp_wb_valid && bq_full && !bq_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (bq_push) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (bq_pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bq_push) begin
      pc_mem[wptr[AW-1:0]]    <= bjp_wb_pc;
      taken_mem[wptr[AW-1:0]] <= bjp_wb_rslv;
      mis_mem[wptr[AW-1:0]]   <= bjp_wb_prdt ^ bjp_wb_rslv;
    end
  end

  assign bht_wb_valid = !bq_empty;
  assign bht_wb_pc    = pc_mem[rptr[AW-1:0]];
  assign bht_wb_taken = taken_mem[rptr[AW-1:0]];
  assign bht_wb_mis   = mis_mem[rptr[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_e203_exu_flush_arb.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_e203_exu_flush_arb : directed scenarios plus randomized model comparison
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_e203_exu_flush_arb;

  localparam int CH  = 3;
  localparam int PW  = 32;
  localparam int BQD = 4;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     cmt_flush_req;
  logic [CH*PW-1:0]  cmt_flush_add_op1;
  logic [CH*PW-1:0]  cmt_flush_add_op2;
  logic [CH-1:0]     cmt_flush_ack;
  logic              pipe_flush_req;
  logic [PW-1:0]     pipe_flush_add_op1;
  logic [PW-1:0]     pipe_flush_add_op2;
  logic              pipe_flush_ack;
  logic              flush_pulse;
  logic [CW-1:0]     flush_cnt;
  logic              bjp_wb_valid;
  logic [PW-1:0]     bjp_wb_pc;
  logic              bjp_wb_prdt;
  logic              bjp_wb_rslv;
  logic              bht_wb_valid;
  logic              bht_wb_ready;
  logic [PW-1:0]     bht_wb_pc;
  logic              bht_wb_taken;
  logic              bht_wb_mis;
  logic              bq_drop;

  int n_cmp  = 0;
  int n_fail = 0;

  e203_exu_flush_arb #(.CH_NUM(CH), .PC_SIZE(PW), .BQ_DEPTH(BQD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmt_flush_req(cmt_flush_req), .cmt_flush_add_op1(cmt_flush_add_op1),
    .cmt_flush_add_op2(cmt_flush_add_op2), .cmt_flush_ack(cmt_flush_ack),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_add_op1(pipe_flush_add_op1),
    .pipe_flush_add_op2(pipe_flush_add_op2), .pipe_flush_ack(pipe_flush_ack),
    .flush_pulse(flush_pulse), .flush_cnt(flush_cnt),
    .bjp_wb_valid(bjp_wb_valid), .bjp_wb_pc(bjp_wb_pc),
    .bjp_wb_prdt(bjp_wb_prdt), .bjp_wb_rslv(bjp_wb_rslv),
    .bht_wb_valid(bht_wb_valid), .bht_wb_ready(bht_wb_ready),
    .bht_wb_pc(bht_wb_pc), .bht_wb_taken(bht_wb_taken),
    .bht_wb_mis(bht_wb_mis), .bq_drop(bq_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] op1_of(int ch);
    return 32'h1000_0000 + PW'(ch);
  endfunction

  function automatic logic [PW-1:0] op2_of(int ch);
    return 32'h2000_0000 + PW'(ch);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmt_flush_req  = '0;
    pipe_flush_ack = 1'b0;
    bjp_wb_valid   = 1'b0;
    bjp_wb_pc      = '0;
    bjp_wb_prdt    = 1'b0;
    bjp_wb_rslv    = 1'b0;
    bht_wb_ready   = 1'b0;
    for (int i = 0; i < CH; i++) begin
      cmt_flush_add_op1[i*PW +: PW] = op1_of(i);
      cmt_flush_add_op2[i*PW +: PW] = op2_of(i);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bjp_wb_valid = 1'b1;
    #1;
    n_cmp++; if (bht_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bht_valid: got %b want 0", bht_wb_valid); end
    n_cmp++; if (bq_drop !== 1'b0) begin n_fail++; $display("FAIL reset_bq_drop: got %b want 0", bq_drop); end
    n_cmp++; if (pipe_flush_req !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_req: got %b want 0", pipe_flush_req); end
    n_cmp++; if (cmt_flush_ack !== 3'b000) begin n_fail++; $display("FAIL reset_cmt_ack: got %b want 000", cmt_flush_ack); end
    n_cmp++; if (flush_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", flush_pulse); end
    tick();
    tick();
    rst = 1'b0;
    bjp_wb_valid = 1'b0;
    #1;
    n_cmp++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt); end
    n_cmp++; if (bht_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_push: got %b want 0", bht_wb_valid); end
    tick();
  endtask

  task automatic test_single_grant();
    apply_reset();
    cmt_flush_req  = 3'b110;
    pipe_flush_ack = 1'b1;
    #1;
    n_cmp++; if (pipe_flush_req !== 1'b1) begin n_fail++; $display("FAIL sg_req: got %b want 1", pipe_flush_req); end
    n_cmp++; if (pipe_flush_add_op1 !== op1_of(1)) begin n_fail++; $display("FAIL sg_op1: got %h want %h", pipe_flush_add_op1, op1_of(1)); end
    n_cmp++; if (pipe_flush_add_op2 !== op2_of(1)) begin n_fail++; $display("FAIL sg_op2: got %h want %h", pipe_flush_add_op2, op2_of(1)); end
    n_cmp++; if (cmt_flush_ack !== 3'b010) begin n_fail++; $display("FAIL sg_ack: got %b want 010", cmt_flush_ack); end
    n_cmp++; if (flush_pulse !== 1'b1) begin n_fail++; $display("FAIL sg_pulse: got %b want 1", flush_pulse); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL sg_cnt: got %0d want 1", flush_cnt); end
    n_cmp++; if (cmt_flush_ack !== 3'b000) begin n_fail++; $display("FAIL sg_ack_idle: got %b want 000", cmt_flush_ack); end
    tick();
  endtask

  task automatic test_grant_lock();
    apply_reset();
    for (int c = 1; c <= 3; c++) begin
      cmt_flush_req  = (c == 1) ? 3'b100 : 3'b101;
      pipe_flush_ack = 1'b0;
      #1;
      n_cmp++; if (pipe_flush_add_op1 !== op1_of(2)) begin n_fail++; $display("FAIL lock_op1_c%0d: got %h want %h", c, pipe_flush_add_op1, op1_of(2)); end
      n_cmp++; if (cmt_flush_ack !== 3'b000) begin n_fail++; $display("FAIL lock_ack_c%0d: got %b want 000", c, cmt_flush_ack); end
      tick();
    end
    cmt_flush_req  = 3'b101;
    pipe_flush_ack = 1'b1;
    #1;
    n_cmp++; if (cmt_flush_ack !== 3'b100) begin n_fail++; $display("FAIL lock_ack_c4: got %b want 100", cmt_flush_ack); end
    n_cmp++; if (pipe_flush_add_op2 !== op2_of(2)) begin n_fail++; $display("FAIL lock_op2_c4: got %h want %h", pipe_flush_add_op2, op2_of(2)); end
    tick();
    cmt_flush_req = 3'b001;
    #1;
    n_cmp++; if (cmt_flush_ack !== 3'b001) begin n_fail++; $display("FAIL lock_ack_c5: got %b want 001", cmt_flush_ack); end
    n_cmp++; if (pipe_flush_add_op1 !== op1_of(0)) begin n_fail++; $display("FAIL lock_op1_c5: got %h want %h", pipe_flush_add_op1, op1_of(0)); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (flush_cnt !== 16'd2) begin n_fail++; $display("FAIL lock_cnt: got %0d want 2", flush_cnt); end
    tick();
  endtask

  task automatic test_req_drop();
    apply_reset();
    cmt_flush_req = 3'b010;
    tick();
    // Channel 1 withdraws while channel 0 requests and the IFU acks.
    cmt_flush_req  = 3'b001;
    pipe_flush_ack = 1'b1;
    #1;
    n_cmp++; if (pipe_flush_req !== 1'b0) begin n_fail++; $display("FAIL drop_req: got %b want 0", pipe_flush_req); end
    n_cmp++; if (cmt_flush_ack !== 3'b000) begin n_fail++; $display("FAIL drop_ack: got %b want 000", cmt_flush_ack); end
    n_cmp++; if (flush_pulse !== 1'b0) begin n_fail++; $display("FAIL drop_pulse: got %b want 0", flush_pulse); end
    tick();
    #1;
    n_cmp++; if (pipe_flush_req !== 1'b1) begin n_fail++; $display("FAIL drop_idle_req: got %b want 1", pipe_flush_req); end
    n_cmp++; if (cmt_flush_ack !== 3'b001) begin n_fail++; $display("FAIL drop_idle_ack: got %b want 001", cmt_flush_ack); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d want 1", flush_cnt); end
    tick();
  endtask

  task automatic test_queue_fill();
    logic [PW-1:0] pcs [5];
    logic          prd [5];
    logic          rsl [5];
    logic [PW-1:0] d_pc [4];
    logic          d_tk [4];
    logic          d_ms [4];
    pcs = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
    prd = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rsl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      bjp_wb_valid = 1'b1;
      bjp_wb_pc    = pcs[k];
      bjp_wb_prdt  = prd[k];
      bjp_wb_rslv  = rsl[k];
      #1;
      n_cmp++; if (bq_drop !== (k == 4)) begin n_fail++; $display("FAIL fill_drop_%0d: got %b want %b", k, bq_drop, (k == 4)); end
      if (k == 0) begin
        n_cmp++; if (bht_wb_valid !== 1'b0) begin n_fail++; $display("FAIL fill_no_bypass: got %b want 0", bht_wb_valid); end
      end
      tick();
    end
    bjp_wb_valid = 1'b0;
    #1;
    n_cmp++; if (bq_drop !== 1'b0) begin n_fail++; $display("FAIL fill_drop_idle: got %b want 0", bq_drop); end
    n_cmp++; if (bht_wb_mis !== 1'b1 || bht_wb_taken !== 1'b0) begin n_fail++; $display("FAIL fill_head_flags: got mis=%b taken=%b want mis=1 taken=0", bht_wb_mis, bht_wb_taken); end
    tick();
    bjp_wb_valid = 1'b1;
    bjp_wb_pc    = 32'h60;
    bjp_wb_prdt  = 1'b1;
    bjp_wb_rslv  = 1'b0;
    bht_wb_ready = 1'b1;
    #1;
    n_cmp++; if (bq_drop !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_drop: got %b want 0", bq_drop); end
    n_cmp++; if (bht_wb_pc !== 32'h40) begin n_fail++; $display("FAIL full_pushpop_head: got %h want 00000040", bht_wb_pc); end
    tick();
    bjp_wb_valid = 1'b0;
    d_pc = '{32'h44, 32'h48, 32'h4C, 32'h60};
    d_tk = '{1'b1, 1'b1, 1'b0, 1'b0};
    d_ms = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (bht_wb_valid !== 1'b1 || bht_wb_pc !== d_pc[k]) begin n_fail++; $display("FAIL drain_pc_%0d: got v=%b pc=%h want v=1 pc=%h", k, bht_wb_valid, bht_wb_pc, d_pc[k]); end
      n_cmp++; if (bht_wb_taken !== d_tk[k] || bht_wb_mis !== d_ms[k]) begin n_fail++; $display("FAIL drain_flags_%0d: got taken=%b mis=%b want taken=%b mis=%b", k, bht_wb_taken, bht_wb_mis, d_tk[k], d_ms[k]); end
      tick();
    end
    #1;
    n_cmp++; if (bht_wb_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", bht_wb_valid); end
    tick();
    bjp_wb_valid = 1'b1;
    bjp_wb_pc    = 32'h70;
    #1;
    n_cmp++; if (bht_wb_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_valid: got %b want 0", bht_wb_valid); end
    tick();
    bjp_wb_valid = 1'b0;
    bht_wb_ready = 1'b0;
    #1;
    n_cmp++; if (bht_wb_valid !== 1'b1 || bht_wb_pc !== 32'h70) begin n_fail++; $display("FAIL empty_pop_head: got v=%b pc=%h want v=1 pc=00000070", bht_wb_valid, bht_wb_pc); end
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    bht_wb_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bjp_wb_valid = 1'b1;
      bjp_wb_pc    = 32'h100 + 32'(4 * k);
      bjp_wb_prdt  = 1'b0;
      bjp_wb_rslv  = (k % 2 == 1);
      #1;
      n_cmp++; if (bq_drop !== 1'b0) begin n_fail++; $display("FAIL wrap_drop_%0d: got %b want 0", k, bq_drop); end
      if (k == 0) begin
        n_cmp++; if (bht_wb_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_first_valid: got %b want 0", bht_wb_valid); end
      end else begin
        n_cmp++; if (bht_wb_valid !== 1'b1 || bht_wb_pc !== 32'h100 + 32'(4 * (k - 1))) begin n_fail++; $display("FAIL wrap_pc_%0d: got v=%b pc=%h want v=1 pc=%h", k, bht_wb_valid, bht_wb_pc, 32'h100 + 32'(4 * (k - 1))); end
        n_cmp++; if (bht_wb_taken !== ((k - 1) % 2 == 1)) begin n_fail++; $display("FAIL wrap_taken_%0d: got %b want %b", k, bht_wb_taken, ((k - 1) % 2 == 1)); end
      end
      tick();
    end
    bjp_wb_valid = 1'b0;
    #1;
    n_cmp++; if (bht_wb_pc !== 32'h124) begin n_fail++; $display("FAIL wrap_last: got %h want 00000124", bht_wb_pc); end
    tick();
    #1;
    n_cmp++; if (bht_wb_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b want 0", bht_wb_valid); end
    tick();
  endtask

  task automatic test_random();
    bit            locked;
    int            lock_ch;
    logic [CW-1:0] cnt;
    logic [CH-1:0] req_r;
    logic [PW+1:0] q [$];
    apply_reset();
    locked  = 1'b0;
    lock_ch = 0;
    cnt     = '0;
    req_r   = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int            sel;
      bit            e_req;
      bit            e_pop;
      bit            e_push;
      logic [CH-1:0] e_ack;
      logic [PW+1:0] got;
      cmt_flush_req = req_r;
      for (int i = 0; i < CH; i++) begin
        cmt_flush_add_op1[i*PW +: PW] = $urandom;
        cmt_flush_add_op2[i*PW +: PW] = $urandom;
      end
      pipe_flush_ack = ($urandom_range(0, 2) == 0);
      bjp_wb_valid   = ($urandom_range(0, 4) < 3);
      bjp_wb_pc      = $urandom;
      bjp_wb_prdt    = $urandom_range(0, 1);
      bjp_wb_rslv    = $urandom_range(0, 1);
      bht_wb_ready   = ($urandom_range(0, 4) < 2);
      #1;
      if (locked) begin
        sel   = lock_ch;
        e_req = req_r[lock_ch];
      end else begin
        sel = 0;
        while (sel < CH - 1 && !req_r[sel]) sel++;
        e_req = (req_r != 0);
      end
      e_ack = '0;
      e_ack[sel] = e_req && pipe_flush_ack;
      n_cmp++; if (pipe_flush_req !== e_req) begin n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", cyc, pipe_flush_req, e_req); end
      n_cmp++; if (cmt_flush_ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack c%0d: got %b want %b", cyc, cmt_flush_ack, e_ack); end
      n_cmp++; if (flush_pulse !== (e_req && pipe_flush_ack)) begin n_fail++; $display("FAIL rnd_pulse c%0d: got %b want %b", cyc, flush_pulse, e_req && pipe_flush_ack); end
      n_cmp++; if (flush_cnt !== cnt) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, flush_cnt, cnt); end
      if (e_req) begin
        n_cmp++; if (pipe_flush_add_op1 !== cmt_flush_add_op1[sel*PW +: PW] || pipe_flush_add_op2 !== cmt_flush_add_op2[sel*PW +: PW]) begin n_fail++; $display("FAIL rnd_ops c%0d: got %h/%h want %h/%h", cyc, pipe_flush_add_op1, pipe_flush_add_op2, cmt_flush_add_op1[sel*PW +: PW], cmt_flush_add_op2[sel*PW +: PW]); end
      end
      e_pop  = (q.size() > 0) && bht_wb_ready;
      e_push = bjp_wb_valid && (q.size() < BQD || e_pop);
      n_cmp++; if (bht_wb_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_bq_valid c%0d: got %b want %b", cyc, bht_wb_valid, q.size() > 0); end
      n_cmp++; if (bq_drop !== (bjp_wb_valid && !e_push)) begin n_fail++; $display("FAIL rnd_bq_drop c%0d: got %b want %b", cyc, bq_drop, bjp_wb_valid && !e_push); end
      if (q.size() > 0) begin
        got = {bht_wb_pc, bht_wb_taken, bht_wb_mis};
        n_cmp++; if (got !== q[0]) begin n_fail++; $display("FAIL rnd_bq_head c%0d: got %h want %h", cyc, got, q[0]); end
      end
      if (e_pop) void'(q.pop_front());
      if (e_push) q.push_back({bjp_wb_pc, bjp_wb_rslv, bjp_wb_prdt ^ bjp_wb_rslv});
      if (e_req && pipe_flush_ack) cnt = cnt + 1'b1;
      if (!locked && e_req && !pipe_flush_ack) begin
        locked  = 1'b1;
        lock_ch = sel;
      end else if (locked && (!e_req || pipe_flush_ack)) begin
        locked = 1'b0;
      end
      // Requesters mostly hold until acked, occasionally withdraw.
      for (int i = 0; i < CH; i++) begin
        if (e_ack[i]) req_r[i] = 1'b0;
        else if (req_r[i]) req_r[i] = ($urandom_range(0, 19) != 0);
        else req_r[i] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    cmt_flush_req  = 3'b001;
    pipe_flush_ack = 1'b1;
    bjp_wb_valid   = 1'b1;
    bjp_wb_pc      = 32'h200;
    tick();
    cmt_flush_req  = 3'b100;
    pipe_flush_ack = 1'b0;
    bjp_wb_pc      = 32'h204;
    tick();
    bjp_wb_valid = 1'b0;
    #1;
    n_cmp++; if (flush_cnt !== 16'd1 || bht_wb_valid !== 1'b1) begin n_fail++; $display("FAIL rmh_pre: got cnt=%0d v=%b want cnt=1 v=1", flush_cnt, bht_wb_valid); end
    #2;
    cmt_flush_req = 3'b001;
    rst = 1'b1;
    #1;
    n_cmp++; if (pipe_flush_req !== 1'b1 || pipe_flush_add_op1 !== op1_of(0)) begin n_fail++; $display("FAIL rmh_idle: got req=%b op1=%h want req=1 op1=%h", pipe_flush_req, pipe_flush_add_op1, op1_of(0)); end
    n_cmp++; if (bht_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rmh_bq: got %b want 0", bht_wb_valid); end
    n_cmp++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL rmh_cnt: got %0d want 0", flush_cnt); end
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    n_cmp++; if (bht_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rmh_after: got %b want 0", bht_wb_valid); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_grant();
    test_grant_lock();
    test_req_drop();
    test_queue_fill();
    test_wrap();
    test_random();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
